// File: rtl/ncl_mul_pkg.sv
// ncl_mul_pkg: shared state type and dual-rail helpers for the
// clocked controller in front of the NCL signed multiplier array.
package ncl_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        NULL,
        RESP
    } state_t;

    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_0    = 2'b01;
    localparam logic [1:0] DR_1    = 2'b10;

    localparam int DR_W = 8;

    function automatic logic [1:0] dr_bit(input logic v);
        return v ? DR_1 : DR_0;
    endfunction

    function automatic logic [2*DR_W-1:0] dr_encode(
        input logic [DR_W-1:0] v
    );
        logic [2*DR_W-1:0] e;
        for (int i = 0; i < DR_W; i++) begin
            e[2*i +: 2] = dr_bit(v[i]);
        end
        return e;
    endfunction

endpackage

// File: rtl/ncl_sync.sv
// ncl_sync: multi-flop synchronizer for one asynchronous
// completion signal, cleared asynchronously with the controller.
module ncl_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] ff;

    // shift the raw level through the flop chain
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[N-2:0], d};
        end
    end

    assign q = ff[N-1];

endmodule

// File: rtl/ncl_mul_seq.sv
// ncl_mul_seq: round-robin controller sharing one dual-rail NCL
// multiplier between two requesters. NCL_MUL_WATCHDOG_EN adds wd_timeout.
module ncl_mul_seq
    import ncl_mul_pkg::*;
#(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           init_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    output logic [1:0]     resp_valid,
    input  logic [1:0]     resp_ready,
    output logic [2*W-1:0] resp_p,
    output logic           resp_err,
    output logic [2*W-1:0] a_dr,
    output logic [2*W-1:0] b_dr,
    input  logic           in_comp,
    input  logic [4*W-1:0] p_dr,
    output logic           p_comp
`ifdef NCL_MUL_WATCHDOG_EN
    ,
    output logic           wd_timeout
`endif
);

    state_t state;
    logic   rr_ptr;
    logic   gnt;

    logic in_comp_s;
    logic p_full_s;
    logic p_null_s;

    logic           p_full;
    logic           p_null;
    logic           p_err;
    logic [2*W-1:0] p_val;

    logic           pick;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [2*W-1:0] enc_a;
    logic [2*W-1:0] enc_b;

    logic fire;
    logic drop;

    ncl_sync #(.STAGES(SYNC_STAGES)) u_sync_in (
        .clk   (clk),
        .clr_n (init_n),
        .d     (in_comp),
        .q     (in_comp_s)
    );

    ncl_sync #(.STAGES(SYNC_STAGES)) u_sync_full (
        .clk   (clk),
        .clr_n (init_n),
        .d     (p_full),
        .q     (p_full_s)
    );

    ncl_sync #(.STAGES(SYNC_STAGES)) u_sync_null (
        .clk   (clk),
        .clr_n (init_n),
        .d     (p_null),
        .q     (p_null_s)
    );

    // product wavefront flags and rail-1 decode of the array output
    always_comb begin
        p_full = 1'b1;
        p_null = 1'b1;
        p_err  = 1'b0;
        p_val  = '0;
        for (int i = 0; i < 2*W; i++) begin
            p_full   = p_full & (p_dr[2*i+1] | p_dr[2*i]);
            p_null   = p_null & ~(p_dr[2*i+1] | p_dr[2*i]);
            p_err    = p_err | (p_dr[2*i+1] & p_dr[2*i]);
            p_val[i] = p_dr[2*i+1];
        end
    end

    // round-robin pick: rr_ptr wins a tie, a lone requester always wins
    always_comb begin
        pick  = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
        sel_a = pick ? req_a[2*W-1:W] : req_a[W-1:0];
        sel_b = pick ? req_b[2*W-1:W] : req_b[W-1:0];
    end

    if (W == DR_W) begin : g_enc_pkg
        assign enc_a = dr_encode(sel_a);
        assign enc_b = dr_encode(sel_b);
    end else begin : g_enc_loop
        // operand widths other than the package width encode bit by bit
        always_comb begin
            enc_a = '0;
            enc_b = '0;
            for (int i = 0; i < W; i++) begin
                enc_a[2*i +: 2] = dr_bit(sel_a[i]);
                enc_b[2*i +: 2] = dr_bit(sel_b[i]);
            end
        end
    end

`ifdef NCL_MUL_WATCHDOG_EN
    logic [15:0] wd_cnt;
    state_t      wd_last;
    logic        wd_drop;

    assign fire = (wd_cnt == 16'hFFFF) &&
                  (state == DATA || state == NULL);
    assign drop = wd_drop;

    // stall counter restarts on any state change, runs in DATA/NULL
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            wd_cnt     <= '0;
            wd_last    <= IDLE;
            wd_drop    <= 1'b0;
            wd_timeout <= 1'b0;
        end else begin
            wd_last <= state;
            if (state != wd_last) begin
                wd_cnt <= '0;
            end else if (state == DATA || state == NULL) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (fire) begin
                wd_timeout <= 1'b1;
                wd_drop    <= 1'b1;
            end else if (state == IDLE) begin
                wd_drop <= 1'b0;
            end
        end
    end
`else
    assign fire = 1'b0;
    assign drop = 1'b0;
`endif

    // four-phase handshake FSM with registered array and requester outputs
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            gnt        <= 1'b0;
            a_dr       <= {(2*W){DR_NULL[0]}};
            b_dr       <= {(2*W){DR_NULL[0]}};
            p_comp     <= 1'b1;
            req_ready  <= 2'b00;
            resp_valid <= 2'b00;
            resp_p     <= '0;
            resp_err   <= 1'b0;
        end else begin
            req_ready <= 2'b00;
            unique case (state)
                IDLE: begin
                    if ((|req_valid) && in_comp_s) begin
                        gnt       <= pick;
                        rr_ptr    <= ~pick;
                        req_ready <= pick ? 2'b10 : 2'b01;
                        a_dr      <= enc_a;
                        b_dr      <= enc_b;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (p_full_s && !in_comp_s) begin
                        resp_p   <= p_val;
                        resp_err <= p_err;
                        a_dr     <= '0;
                        b_dr     <= '0;
                        p_comp   <= 1'b0;
                        state    <= NULL;
                    end
                end
                NULL: begin
                    if (p_null_s && in_comp_s) begin
                        p_comp <= 1'b1;
                        if (drop) begin
                            state <= IDLE;
                        end else begin
                            resp_valid[gnt] <= 1'b1;
                            state           <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (resp_ready[gnt]) begin
                        resp_valid <= 2'b00;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (fire) begin
                a_dr   <= '0;
                b_dr   <= '0;
                p_comp <= 1'b0;
                state  <= NULL;
            end
        end
    end

endmodule

// File: tb/tb_ncl_mul_seq.sv
// tb_ncl_mul_seq: randomized scoreboard bench for ncl_mul_seq with a
// behavioural dual-rail array model driving the completion handshakes.
module tb_ncl_mul_seq;

    logic        clk;
    logic        init_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [15:0] resp_p;
    logic        resp_err;
    logic [15:0] a_dr;
    logic [15:0] b_dr;
    logic        in_comp;
    logic [31:0] p_dr;
    logic        p_comp;
`ifdef NCL_MUL_WATCHDOG_EN
    logic        wd_timeout;
`endif

    typedef struct {
        int         r;
        logic [7:0] a;
        logic [7:0] b;
    } op_t;

    op_t exp_q[$];
    bit  err_q[$];
    int  gl[$];

    int tests = 0;
    int fails = 0;

    bit stall;
    bit force_err;
    bit rand_err;
    int bp_cfg;

    ncl_mul_seq #(.W(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .init_n     (init_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_p     (resp_p),
        .resp_err   (resp_err),
        .a_dr       (a_dr),
        .b_dr       (b_dr),
        .in_comp    (in_comp),
        .p_dr       (p_dr),
        .p_comp     (p_comp)
`ifdef NCL_MUL_WATCHDOG_EN
        ,
        .wd_timeout (wd_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic logic [1:0] oh(input int i);
        return (i == 1) ? 2'b10 : 2'b01;
    endfunction

    // dual-rail: true rail high means 1, false rail high means 0
    function automatic logic [15:0] enc8(input logic [7:0] v);
        logic [15:0] e;
        for (int i = 0; i < 8; i++) e[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        return e;
    endfunction

    function automatic logic [31:0] enc16(input logic [15:0] v);
        logic [31:0] e;
        for (int i = 0; i < 16; i++) e[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        return e;
    endfunction

    function automatic logic [7:0] dec8(input logic [15:0] x);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = x[2*i+1];
        return v;
    endfunction

    function automatic bit full8(input logic [15:0] x);
        for (int i = 0; i < 8; i++) if (x[2*i +: 2] == 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    // behavioural self-timed array with random per-pair wavefront arrival
    initial begin : array_model
        logic [31:0] tgt;
        logic [7:0]  av;
        logic [7:0]  bv;
        int          ia;
        int          ib;
        bit          busy;
        bit          inj;
        bit          ifull;
        bit          inull;
        in_comp = 1'b1;
        p_dr    = '0;
        busy    = 1'b0;
        tgt     = '0;
        forever begin
            @(negedge clk);
            if (!init_n) begin
                in_comp = 1'b1;
                p_dr    = '0;
                busy    = 1'b0;
            end else begin
                ifull = full8(a_dr) && full8(b_dr);
                inull = (a_dr == 16'h0) && (b_dr == 16'h0);
                if (in_comp && ifull && $urandom_range(2) == 0)
                    in_comp = 1'b0;
                else if (!in_comp && inull && $urandom_range(2) == 0)
                    in_comp = 1'b1;
                if (p_comp && ifull && !stall) begin
                    if (!busy) begin
                        av  = dec8(a_dr);
                        bv  = dec8(b_dr);
                        ia  = $signed(av);
                        ib  = $signed(bv);
                        tgt = enc16(16'(ia * ib));
                        inj = force_err || (rand_err && $urandom_range(3) == 0);
                        if (inj) tgt[7:6] = 2'b11;
                        err_q.push_back(inj);
                        busy = 1'b1;
                    end
                    for (int i = 0; i < 16; i++)
                        if ($urandom_range(1) == 1) p_dr[2*i +: 2] = tgt[2*i +: 2];
                end else if (!p_comp) begin
                    busy = 1'b0;
                    for (int i = 0; i < 16; i++)
                        if ($urandom_range(1) == 1) p_dr[2*i +: 2] = 2'b00;
                end
            end
        end
    end

    // monitor: pops the scoreboard on each response and drives resp_ready
    initial begin : monitor
        bit          act;
        int          hold;
        int          ridx;
        int          falls;
        int          ia;
        int          ib;
        logic        prev_pc;
        logic [15:0] cap_p;
        logic        cap_e;
        logic [15:0] ep;
        bit          ee;
        op_t         e;
        act        = 1'b0;
        hold       = 0;
        ridx       = 0;
        falls      = 0;
        prev_pc    = 1'b1;
        resp_ready = 2'b00;
        forever begin
            @(negedge clk);
            if (!init_n) begin
                act        = 1'b0;
                prev_pc    = 1'b1;
                falls      = 0;
                resp_ready = 2'b00;
                continue;
            end
            if (req_ready != 2'b00) falls = 0;
            if (prev_pc && !p_comp) falls++;
            prev_pc = p_comp;
            if (resp_valid != 2'b00) begin
                if (!act) begin
                    act = 1'b1;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL resp_unexpected: got %b, expected none",
                                 resp_valid);
                        ridx = resp_valid[1] ? 1 : 0;
                    end else begin
                        e    = exp_q.pop_front();
                        ridx = e.r;
                        chk("err_q_entry", 32'(err_q.size() != 0), 32'd1);
                        ee   = (err_q.size() != 0) ? err_q.pop_front() : 1'b0;
                        ia   = $signed(e.a);
                        ib   = $signed(e.b);
                        ep   = 16'(ia * ib);
                        if (ee) ep[3] = 1'b1;
                        chk("resp_idx", 32'(resp_valid), 32'(oh(ridx)));
                        chk("resp_p", 32'(resp_p), 32'(ep));
                        chk("resp_err", 32'(resp_err), 32'(ee));
                        chk("p_comp_falls", 32'(falls), 32'd1);
                        chk("p_comp_back", 32'(p_comp), 32'd1);
                    end
                    cap_p = resp_p;
                    cap_e = resp_err;
                    hold  = (bp_cfg > 0) ? bp_cfg : $urandom_range(3);
                end else begin
                    chk("hold_p", 32'(resp_p), 32'(cap_p));
                    chk("hold_err", 32'(resp_err), 32'(cap_e));
                    chk("hold_valid", 32'(resp_valid), 32'(oh(ridx)));
                    chk("hold_no_grant", 32'(req_ready), 32'd0);
                end
                resp_ready = ($urandom_range(1) == 1) ? oh(1 - ridx) : 2'b00;
                if (hold > 0) hold--;
                else resp_ready = resp_ready | oh(ridx);
            end else begin
                act        = 1'b0;
                resp_ready = 2'($urandom_range(3));
            end
        end
    end

    task automatic issue(input int r, input logic [7:0] a,
                         input logic [7:0] b);
        int  n;
        op_t o;
        n = 0;
        req_a[r*8 +: 8] = a;
        req_b[r*8 +: 8] = b;
        req_valid[r]    = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[r] && n < 4000);
        if (!req_ready[r]) begin
            tests++;
            fails++;
            $display("FAIL grant_timeout: req%0d got no req_ready, expected one", r);
        end else begin
            chk("a_dr", 32'(a_dr), 32'(enc8(a)));
            chk("b_dr", 32'(b_dr), 32'(enc8(b)));
            o.r = r;
            o.a = a;
            o.b = b;
            exp_q.push_back(o);
            gl.push_back(r);
        end
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || resp_valid != 2'b00) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (exp_q.size() != 0 || resp_valid != 2'b00) begin
            fails++;
            $display("FAIL idle_timeout: got %0d pending, expected 0",
                     exp_q.size());
        end
    endtask

    initial begin : guard
        #1500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0] bnd_a [6];
        logic [7:0] bnd_b [6];
        bnd_a = '{8'h7F, 8'h80, 8'h00, 8'hFF, 8'h80, 8'h01};
        bnd_b = '{8'h7F, 8'h7F, 8'h80, 8'hFF, 8'h80, 8'hFF};
        stall     = 1'b0;
        force_err = 1'b0;
        rand_err  = 1'b0;
        bp_cfg    = 0;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        init_n    = 1'b1;
        #2 init_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_dr", 32'(a_dr), 32'd0);
        chk("rst_b_dr", 32'(b_dr), 32'd0);
        chk("rst_p_comp", 32'(p_comp), 32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_p", 32'(resp_p), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
`ifdef NCL_MUL_WATCHDOG_EN
        chk("rst_wd", 32'(wd_timeout), 32'd0);
`endif
        init_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(0, 8'h05, 8'hFD);
        wait_idle();

        gl.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) issue(0, 8'($urandom), 8'($urandom));
            end
            begin
                for (int i = 0; i < 4; i++) issue(1, 8'($urandom), 8'($urandom));
            end
        join
        wait_idle();
        chk("rr_first", 32'(gl.size() > 0 ? gl[0] : -1), 32'd1);
        for (int i = 1; i < gl.size(); i++)
            chk("rr_alt", 32'(gl[i]), 32'(1 - gl[i-1]));

        force_err = 1'b1;
        issue(1, 8'h7F, 8'h81);
        wait_idle();
        force_err = 1'b0;

        bp_cfg = 20;
        fork
            issue(0, 8'h3C, 8'hC3);
            issue(1, 8'h9A, 8'h21);
        join
        wait_idle();
        bp_cfg = 0;

        stall = 1'b1;
        issue(0, 8'h11, 8'h22);
        repeat (6) @(negedge clk);
        init_n = 1'b0;
        #1;
        chk("mid_rst_a_dr", 32'(a_dr), 32'd0);
        chk("mid_rst_b_dr", 32'(b_dr), 32'd0);
        chk("mid_rst_p_comp", 32'(p_comp), 32'd1);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        exp_q.delete();
        err_q.delete();
        stall = 1'b0;
        repeat (3) @(negedge clk);
        init_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(0, 8'h80, 8'h80);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            issue(i % 2, bnd_a[i], bnd_b[i]);
            wait_idle();
        end

        rand_err = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(1) == 1) begin
                fork
                    issue(0, 8'($urandom), 8'($urandom));
                    issue(1, 8'($urandom), 8'($urandom));
                join
            end else begin
                issue($urandom_range(1), 8'($urandom), 8'($urandom));
            end
        end
        wait_idle();
        rand_err = 1'b0;

`ifdef NCL_MUL_WATCHDOG_EN
        begin
            int n;
            stall = 1'b1;
            issue(1, 8'h12, 8'h34);
            n = 0;
            while (!wd_timeout && n < 70000) begin
                @(negedge clk);
                n++;
            end
            chk("wd_timeout", 32'(wd_timeout), 32'd1);
            if (exp_q.size() != 0) void'(exp_q.pop_back());
            stall = 1'b0;
            repeat (30) @(negedge clk);
            chk("wd_no_resp", 32'(resp_valid), 32'd0);
            chk("wd_a_dr_null", 32'(a_dr), 32'd0);
            issue(0, 8'hF0, 8'h0F);
            wait_idle();
            chk("wd_sticky", 32'(wd_timeout), 32'd1);
        end
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("err_q_empty", 32'(err_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
